// File: rtl/buttons_debounce_multi.sv
// NUM_CH-channel debouncer for active-low buttons: 2-flop sync, stability filter, strobes, toggle latch.
// Optional long-press strobe enabled by defining BUTTONS_DEBOUNCE_LONGPRESS_EN.
module buttons_debounce_multi #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned LONG_CYCLES     = 12000000,
    parameter logic        TOGGLE_INIT     = 1'b0
) (
    input  logic              i_hwclk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_btn_n,
    output logic [NUM_CH-1:0] o_pressed,
    output logic [NUM_CH-1:0] o_press_evt,
    output logic [NUM_CH-1:0] o_release_evt,
    output logic [NUM_CH-1:0] o_toggle,
    output logic [NUM_CH-1:0] o_long_evt
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] r_s1;
    logic [NUM_CH-1:0] r_s2;
    logic [NUM_CH-1:0] r_pressed;
    logic [NUM_CH-1:0] r_press_evt;
    logic [NUM_CH-1:0] r_release_evt;
    logic [NUM_CH-1:0] r_toggle;
    logic [CW-1:0]     r_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_raw_p;

    assign w_raw_p = ~r_s2;

    // Sync chain plus per-channel stability counter; any sample matching the
    // accepted level restarts the count.
    always_ff @(posedge i_hwclk or posedge i_rst) begin
        if (i_rst) begin
            r_s1          <= '1;
            r_s2          <= '1;
            r_pressed     <= '0;
            r_press_evt   <= '0;
            r_release_evt <= '0;
            r_toggle      <= {NUM_CH{TOGGLE_INIT}};
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            r_s1          <= i_btn_n;
            r_s2          <= r_s1;
            r_press_evt   <= '0;
            r_release_evt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_raw_p[i] == r_pressed[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_cnt[i]         <= '0;
                    r_pressed[i]     <= w_raw_p[i];
                    r_press_evt[i]   <= w_raw_p[i];
                    r_release_evt[i] <= ~w_raw_p[i];
                    if (w_raw_p[i]) r_toggle[i] <= ~r_toggle[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign o_pressed     = r_pressed;
    assign o_press_evt   = r_press_evt;
    assign o_release_evt = r_release_evt;
    assign o_toggle      = r_toggle;

`ifdef BUTTONS_DEBOUNCE_LONGPRESS_EN
    localparam int unsigned   LW       = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES);

    logic [LW-1:0]     r_hold [NUM_CH];
    logic [NUM_CH-1:0] r_long_evt;

    // Hold counter saturates at LONG_CYCLES so the strobe fires once per hold.
    always_ff @(posedge i_hwclk or posedge i_rst) begin
        if (i_rst) begin
            r_long_evt <= '0;
            for (int i = 0; i < NUM_CH; i++) r_hold[i] <= '0;
        end else begin
            r_long_evt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!r_pressed[i]) begin
                    r_hold[i] <= '0;
                end else if (r_hold[i] != HOLD_MAX) begin
                    r_hold[i] <= r_hold[i] + LW'(1);
                    if (r_hold[i] == HOLD_MAX - LW'(1)) r_long_evt[i] <= 1'b1;
                end
            end
        end
    end

    assign o_long_evt = r_long_evt;
`else
    logic [31:0] w_unused_long;

    assign w_unused_long = 32'(LONG_CYCLES);
    assign o_long_evt    = '0;
`endif

endmodule
